uart_cmd_parser: RTL and testbench
==================================

// Module: uart_cmd_parser
// PURPOSE
//  Frames the byte stream from the RS-232 receiver (rx_byte/rx_valid) into register commands.
//  Sits directly downstream of the serial decoder and drives the CPLD register file.
//  Frame: SYNC, CMD, [DATA], [CHK]. CMD[7] = 1 for write, 0 for read; CMD[6:0] = address.
//  Valid frames emit a single-cycle reg_we/reg_re strobe. Bad or stalled frames are counted and dropped.
// PARAMETERS
//  SYNC_BYTE       8'hA5  frame start marker
//  TIMEOUT_CYCLES  40     clocks allowed between bytes inside a frame (about 4 byte times at 10 clk/byte)
//  TO_W            6      timeout counter width; must hold TIMEOUT_CYCLES
// PORTS
//  clock      in   1  single system clock (the serial bit clock); all logic on posedge
//  reset_n    in   1  synchronous, active-low reset
//  rx_byte    in   8  received byte; sampled only when rx_valid=1
//  rx_valid   in   1  one-clock pulse per received byte
//  reg_addr   out  7  address of last accepted command
//  reg_wdata  out  8  write data of last accepted write
//  reg_we     out  1  one-clock write strobe
//  reg_re     out  1  one-clock read strobe
//  frame_err  out  1  one-clock pulse on checksum failure or timeout
//  err_count  out  8  frame errors since reset; saturates at 8'hFF
//  busy       out  1  high whenever state != IDLE
// BEHAVIOUR
//  Reset (reset_n=0 at posedge):
//   - state=IDLE; all outputs 0; timeout counter 0; partial-frame registers 0.
//   - Reset mid-frame discards the frame with no strobe and no error.
//  States: IDLE -> CMD -> (DATA if CMD[7]) -> CHK -> IDLE. Each transition needs rx_valid.
//   - IDLE: byte==SYNC_BYTE -> CMD. Any other byte is ignored silently (no error).
//   - CMD: latch rx_byte. Write -> DATA; read -> CHK.
//   - DATA: latch the data byte -> CHK.
//   - CHK: expected value = (CMD + DATA) mod 256 for writes, CMD for reads.
//  CHK outcome:
//   - Match: reg_addr/reg_wdata update and reg_we or reg_re = 1 on the clock after the accepting
//     rx_valid edge (latency 1). Reads leave reg_wdata unchanged. Return to IDLE.
//   - Mismatch: frame_err=1 for one clock, err_count += 1 (saturating), no strobe, return to IDLE.
//  In-frame byte handling:
//   - SYNC_BYTE inside a frame is plain data; there is no mid-frame resync.
//   - Back-to-back rx_valid (consecutive clocks) is accepted, one byte per clock.
//  Timeout:
//   - Counter clears on every accepted byte and in IDLE; it increments each clock when
//     busy=1 and rx_valid=0.
//   - Reaching TIMEOUT_CYCLES -> IDLE, frame_err pulse, err_count += 1.
//   - rx_valid on the clock the count would expire wins: the byte is accepted and the counter clears.
//  Error counter: err_count stays at 8'hFF once reached. frame_err still pulses.
//  Strobes and frame_err are mutually exclusive and never high for two consecutive clocks from one frame.
// CONFIGURATION
//  Macro CMD_CHECKSUM_EN:
//   - Defined: CHK state and checksum byte present, as above.
//   - Undefined: no CHK byte. The strobe fires the clock after CMD (read) or DATA (write).
//     frame_err pulses on timeout only.
// TESTING
//  1. Write: A5,85,3C,C1 -> reg_we=1 one clock after the C1 rx_valid; reg_addr=05, reg_wdata=3C; busy back to 0.
//  2. Read: A5,12,12 -> reg_re=1 one clock later; reg_addr=12; reg_wdata unchanged; no frame_err.
//  3. Bad checksum: A5,85,3C,00 -> no reg_we; frame_err pulse; err_count 0->1;
//     following valid frame A5,01,01 still produces reg_re.
//  4. Timeout: A5,85, then 40 idle clocks -> frame_err and return to IDLE;
//     a byte on clock 39 instead is accepted with no error.
//  5. Noise/reset: 00,FF,A5 in IDLE -> only A5 enters CMD.
//     reset_n=0 after A5,85 -> all outputs 0, no strobe, err_count 0.
//  6. Saturation: 256 bad frames -> err_count holds FF.
//     CMD_CHECKSUM_EN undefined: A5,85,3C -> reg_we with reg_wdata=3C.

Source files
------------

// File: rtl/uart_cmd_parser.sv
// -----------------------------------------------------------------------------
// uart_cmd_parser
//
// Purpose:
//   Frames the byte stream coming out of the RS-232 receiver into register
//   commands for the CPLD register file. A frame is
//     SYNC, CMD, [DATA], [CHK]
//   CMD[7] = 1 selects a write (a DATA byte follows), 0 a read.
//   CMD[6:0] is the register address. A valid frame produces a single-cycle
//   reg_we / reg_re strobe one clock after the byte that completes it.
//   Frames that fail the checksum, or that stall too long between bytes, are
//   dropped. They raise a one-clock frame_err pulse and are counted in a
//   saturating err_count.
//
// Configuration:
//   CMD_CHECKSUM_EN  defined   -> a checksum byte closes every frame.
//                               Its expected value is (CMD + DATA) mod 256
//                               for writes and CMD for reads.
//                    undefined -> there is no checksum byte. The strobe fires
//                               after CMD (read) or after DATA (write), and
//                               only a timeout can raise frame_err.
//
// Parameters:
//   SYNC_BYTE       frame start marker
//   TIMEOUT_CYCLES  idle clocks tolerated between bytes inside a frame
//   TO_W            timeout counter width (must hold TIMEOUT_CYCLES)
//
// Ports:
//   clock      in   1  system clock; all logic runs on posedge
//   reset_n    in   1  synchronous, active-low reset
//   rx_byte    in   8  received byte, qualified by rx_valid
//   rx_valid   in   1  one-clock pulse per received byte
//   reg_addr   out  7  address of the last accepted command
//   reg_wdata  out  8  data of the last accepted write
//   reg_we     out  1  one-clock write strobe
//   reg_re     out  1  one-clock read strobe
//   frame_err  out  1  one-clock pulse on checksum failure or timeout
//   err_count  out  8  frame errors since reset, saturating at 8'hFF
//   busy       out  1  high while a frame is in progress (state != IDLE)
// -----------------------------------------------------------------------------
module uart_cmd_parser #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 40,
  parameter int unsigned TO_W           = 6
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] rx_byte,
  input  logic       rx_valid,
  output logic [6:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  output logic       frame_err,
  output logic [7:0] err_count,
  output logic       busy
);

  // The stored command needs bit 7 only when it takes part in the checksum.
  // Without the checksum, the write/read decision is made in the CMD state
  // itself, so only the address has to be kept.
`ifdef CMD_CHECKSUM_EN
  localparam int unsigned CMD_W = 8;
`else
  localparam int unsigned CMD_W = 7;
`endif

  // The count that expires on this clock if no byte arrives.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMD  = 2'd1,
    S_DATA = 2'd2,
    S_CHK  = 2'd3
  } state_t;

  // State and frame registers
  state_t           r_state;
  logic [CMD_W-1:0] r_cmd;
  logic [TO_W-1:0]  r_to_cnt;
  logic [6:0]       r_addr;
  logic [7:0]       r_wdata;
  logic             r_we;
  logic             r_re;
  logic             r_err;
  logic [7:0]       r_err_cnt;

  // Next-state values
  state_t           w_state_nxt;
  logic [CMD_W-1:0] w_cmd_nxt;
  logic [TO_W-1:0]  w_to_nxt;
  logic [6:0]       w_addr_nxt;
  logic [7:0]       w_wdata_nxt;
  logic             w_we_nxt;
  logic             w_re_nxt;
  logic             w_err_nxt;

`ifdef CMD_CHECKSUM_EN
  logic [7:0] r_data;
  logic [7:0] w_data_nxt;
  logic [7:0] w_expect;

  // The sum wraps naturally in 8 bits, which gives the mod-256 checksum.
  assign w_expect = r_cmd[7] ? (r_cmd + r_data) : r_cmd;
`endif

  // ---------------------------------------------------------------------------
  // Next-state / output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first. Without the
    // defaults, a path that skips an assignment would infer a latch.
    w_state_nxt = r_state;
    w_cmd_nxt   = r_cmd;
    w_addr_nxt  = r_addr;
    w_wdata_nxt = r_wdata;
    w_we_nxt    = 1'b0;
    w_re_nxt    = 1'b0;
    w_err_nxt   = 1'b0;
    // The counter clears on every accepted byte and while IDLE. Only the
    // in-frame idle path below holds or advances it.
    w_to_nxt    = '0;
`ifdef CMD_CHECKSUM_EN
    w_data_nxt  = r_data;
`endif

    // Inter-byte timeout. A byte arriving on the expiring clock takes the
    // rx_valid branch below instead, so the byte wins over the timeout.
    if ((r_state != S_IDLE) && !rx_valid) begin
      if (r_to_cnt == TO_LAST) begin
        w_state_nxt = S_IDLE;
        w_err_nxt   = 1'b1;
      end else begin
        w_to_nxt = r_to_cnt + TO_W'(1);
      end
    end

    if (rx_valid) begin
      unique case (r_state)
        S_IDLE: begin
          // Anything other than SYNC is line noise and is dropped silently.
          if (rx_byte == SYNC_BYTE) begin
            w_state_nxt = S_CMD;
          end
        end

        S_CMD: begin
          w_cmd_nxt = rx_byte[CMD_W-1:0];
`ifdef CMD_CHECKSUM_EN
          w_state_nxt = rx_byte[7] ? S_DATA : S_CHK;
`else
          if (rx_byte[7]) begin
            w_state_nxt = S_DATA;
          end else begin
            // A read completes on its CMD byte. reg_wdata is left unchanged.
            w_re_nxt    = 1'b1;
            w_addr_nxt  = rx_byte[6:0];
            w_state_nxt = S_IDLE;
          end
`endif
        end

        S_DATA: begin
`ifdef CMD_CHECKSUM_EN
          // SYNC_BYTE here is ordinary data; there is no mid-frame resync.
          w_data_nxt  = rx_byte;
          w_state_nxt = S_CHK;
`else
          w_we_nxt    = 1'b1;
          w_addr_nxt  = r_cmd[6:0];
          w_wdata_nxt = rx_byte;
          w_state_nxt = S_IDLE;
`endif
        end

`ifdef CMD_CHECKSUM_EN
        S_CHK: begin
          if (rx_byte == w_expect) begin
            w_addr_nxt = r_cmd[6:0];
            if (r_cmd[7]) begin
              w_we_nxt    = 1'b1;
              w_wdata_nxt = r_data;
            end else begin
              w_re_nxt = 1'b1;
            end
          end else begin
            w_err_nxt = 1'b1;
          end
          w_state_nxt = S_IDLE;
        end
`endif

        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only. All registers
  // then update together on the edge, with no dependence on statement order.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      // A reset mid-frame discards the partial frame. It raises no strobe
      // and no error.
      r_state   <= S_IDLE;
      r_cmd     <= '0;
      r_to_cnt  <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_we      <= 1'b0;
      r_re      <= 1'b0;
      r_err     <= 1'b0;
      r_err_cnt <= '0;
`ifdef CMD_CHECKSUM_EN
      r_data    <= '0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_cmd    <= w_cmd_nxt;
      r_to_cnt <= w_to_nxt;
      r_addr   <= w_addr_nxt;
      r_wdata  <= w_wdata_nxt;
      r_we     <= w_we_nxt;
      r_re     <= w_re_nxt;
      r_err    <= w_err_nxt;
      // Saturate at 8'hFF; frame_err keeps pulsing after that.
      if (w_err_nxt && (r_err_cnt != 8'hFF)) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end
`ifdef CMD_CHECKSUM_EN
      r_data   <= w_data_nxt;
`endif
    end
  end

  assign reg_addr  = r_addr;
  assign reg_wdata = r_wdata;
  assign reg_we    = r_we;
  assign reg_re    = r_re;
  assign frame_err = r_err;
  assign err_count = r_err_cnt;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_cmd_parser.sv
// -----------------------------------------------------------------------------
// tb_uart_cmd_parser
//
// Directed testbench for uart_cmd_parser. Expected values are hand-computed
// constants. With CMD_CHECKSUM_EN defined, frames carry a checksum byte;
// otherwise they end after CMD (read) or DATA (write).
// -----------------------------------------------------------------------------
module tb_uart_cmd_parser;

  logic       clock;
  logic       reset_n;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic [6:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic       frame_err;
  logic [7:0] err_count;
  logic       busy;

  int n_total = 0;
  int n_pass  = 0;

  uart_cmd_parser dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .rx_byte   (rx_byte),
    .rx_valid  (rx_valid),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_we    (reg_we),
    .reg_re    (reg_re),
    .frame_err (frame_err),
    .err_count (err_count),
    .busy      (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
    n_total++;
    if (act === exp_v) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp_v);
    end
  endtask

  // The byte is presented for one posedge. Outputs are then sampled 1 ns
  // after that edge. Consecutive calls keep rx_valid high back to back.
  task automatic send(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(posedge clock);
    #1;
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  // A frame that must end in frame_err: a bad checksum when the checksum is
  // enabled, otherwise a stalled frame.
  task automatic bad_frame();
`ifdef CMD_CHECKSUM_EN
    send(8'hA5); send(8'h85); send(8'h3C); send(8'h00);
`else
    send(8'hA5); idle(40);
`endif
  endtask

  int base_err;

  initial begin
    reset_n  = 1'b0;
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
    idle(2);
    check("rst_we",   32'(reg_we),    0);
    check("rst_re",   32'(reg_re),    0);
    check("rst_err",  32'(frame_err), 0);
    check("rst_cnt",  32'(err_count), 0);
    check("rst_busy", 32'(busy),      0);
    check("rst_addr", 32'(reg_addr),  0);
    check("rst_wd",   32'(reg_wdata), 0);
    reset_n = 1'b1;
    idle(1);

    // 1. Write to address 05 with data 3C
    send(8'hA5);
    check("w_busy", 32'(busy), 1);
`ifdef CMD_CHECKSUM_EN
    send(8'h85); send(8'h3C); send(8'hC1);
`else
    send(8'h85); send(8'h3C);
`endif
    check("w_we",    32'(reg_we),    1);
    check("w_re",    32'(reg_re),    0);
    check("w_addr",  32'(reg_addr),  32'h05);
    check("w_wdata", 32'(reg_wdata), 32'h3C);
    check("w_ferr",  32'(frame_err), 0);
    check("w_idle",  32'(busy),      0);
    idle(1);
    check("w_pulse", 32'(reg_we),    0);

    // 2. Read from address 12; reg_wdata keeps the last write data
`ifdef CMD_CHECKSUM_EN
    send(8'hA5); send(8'h12); send(8'h12);
`else
    send(8'hA5); send(8'h12);
`endif
    check("r_re",    32'(reg_re),    1);
    check("r_we",    32'(reg_we),    0);
    check("r_addr",  32'(reg_addr),  32'h12);
    check("r_wdata", 32'(reg_wdata), 32'h3C);
    check("r_ferr",  32'(frame_err), 0);
    idle(1);
    check("r_pulse", 32'(reg_re),    0);

`ifdef CMD_CHECKSUM_EN
    // 3. Bad checksum is dropped and counted; the next frame still works
    send(8'hA5); send(8'h85); send(8'h3C); send(8'h00);
    check("bad_we",   32'(reg_we),    0);
    check("bad_ferr", 32'(frame_err), 1);
    check("bad_cnt",  32'(err_count), 1);
    check("bad_busy", 32'(busy),      0);
    idle(1);
    check("bad_pulse", 32'(frame_err), 0);
    send(8'hA5); send(8'h01); send(8'h01);
    check("rec_re",   32'(reg_re),    1);
    check("rec_addr", 32'(reg_addr),  32'h01);
    idle(1);
`endif

    // SYNC as in-frame data: write A5 to address 05
`ifdef CMD_CHECKSUM_EN
    send(8'hA5); send(8'h85); send(8'hA5); send(8'h2A);
`else
    send(8'hA5); send(8'h85); send(8'hA5);
`endif
    check("sd_we",    32'(reg_we),    1);
    check("sd_wdata", 32'(reg_wdata), 32'hA5);
    check("sd_ferr",  32'(frame_err), 0);
    idle(1);

    // 4. Timeout boundary: 39 idle clocks survive, the 40th expires
`ifdef CMD_CHECKSUM_EN
    base_err = 1;
`else
    base_err = 0;
`endif
    check("to_base", 32'(err_count), 32'(base_err));
    send(8'hA5); send(8'h85);
    idle(39);
    check("to39_busy", 32'(busy),      1);
    check("to39_ferr", 32'(frame_err), 0);
    idle(1);
    check("to40_ferr", 32'(frame_err), 1);
    check("to40_busy", 32'(busy),      0);
    check("to40_cnt",  32'(err_count), 32'(base_err + 1));
    idle(1);
    check("to_pulse",  32'(frame_err), 0);

    // A byte on the expiring clock is accepted instead
    send(8'hA5); send(8'h85);
    idle(39);
    send(8'h3C);
    check("tow_ferr", 32'(frame_err), 0);
`ifdef CMD_CHECKSUM_EN
    check("tow_busy", 32'(busy), 1);
    send(8'hC1);
`endif
    check("tow_we",  32'(reg_we),    1);
    check("tow_cnt", 32'(err_count), 32'(base_err + 1));
    idle(1);

    // 5. Noise in IDLE is ignored; only SYNC starts a frame
    send(8'h00);
    check("n00_busy", 32'(busy), 0);
    send(8'hFF);
    check("nFF_busy", 32'(busy), 0);
    check("n_cnt",    32'(err_count), 32'(base_err + 1));
    send(8'hA5);
    check("nA5_busy", 32'(busy), 1);
    send(8'h85);

    // Reset mid-frame clears everything with no strobe
    reset_n = 1'b0;
    idle(1);
    check("mr_we",    32'(reg_we),    0);
    check("mr_re",    32'(reg_re),    0);
    check("mr_ferr",  32'(frame_err), 0);
    check("mr_cnt",   32'(err_count), 0);
    check("mr_busy",  32'(busy),      0);
    check("mr_addr",  32'(reg_addr),  0);
    check("mr_wdata", 32'(reg_wdata), 0);
    reset_n = 1'b1;
    idle(1);
`ifdef CMD_CHECKSUM_EN
    send(8'hA5); send(8'h12); send(8'h12);
`else
    send(8'hA5); send(8'h12);
`endif
    check("pr_re",    32'(reg_re),    1);
    check("pr_wdata", 32'(reg_wdata), 0);
    idle(1);

    // 6. Saturation of the error counter
    for (int i = 0; i < 254; i++) bad_frame();
    check("sat_254", 32'(err_count), 32'hFE);
    bad_frame();
    check("sat_255", 32'(err_count), 32'hFF);
    bad_frame();
    check("sat_256",  32'(err_count), 32'hFF);
    check("sat_ferr", 32'(frame_err), 1);
    idle(1);
    check("sat_hold", 32'(err_count), 32'hFF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
